fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues imem reads, holds the
//   IF/ID latch, and applies redirects driven by the control unit's pcsrc_t (Norm/Bran/PCJr/PCJ).
//   Sits between the instruction cache and decode. The hazard unit stalls it; resolved control flow flushes it.
// PARAMETERS
//   PC_INIT    32'h0000_0000  PC value loaded on reset
//   WORD_W     32             instruction/address width
// PORTS
//   CLK          in   1       clock, rising edge
//   nRST         in   1       synchronous active-low reset
//   pcsrc        in   2       pcsrc_t from EX: Norm/Bran/PCJr/PCJ
//   br_taken     in   1       branch condition true; qualifies Bran
//   br_addr      in   32      branch target
//   jr_addr      in   32      register jump target
//   j_addr       in   32      absolute jump target, already formed upstream
//   stall        in   1       hold IF/ID and PC (hazard unit)
//   halt         in   1       stop fetching permanently until reset
//   ihit         in   1       imem returns imemload this cycle
//   imemload     in   32      instruction data
//   imemREN      out  1       imem read request
//   imemaddr     out  32      imem address
//   ifid_instr   out  32      latched instruction
//   ifid_npc     out  32      latched PC+4 of that instruction
//   ifid_valid   out  1       IF/ID holds a real instruction
// BEHAVIOUR
//   - Reset (nRST=0 at edge): PC=PC_INIT, state=RUN, ifid_instr=0, ifid_npc=0, ifid_valid=0, redirect buffer cleared.
//     imemREN=0 in the reset cycle. Reset wins over every other input.
//   - redirect = (pcsrc==Bran & br_taken) | pcsrc==PCJr | pcsrc==PCJ. Target mux: Bran->br_addr, PCJr->jr_addr, PCJ->j_addr.
//   - imemaddr = PC in RUN. imemaddr = held PC in DRAIN. PC[1:0] always 0; low bits of targets are ignored.
//   - FSM states:
//     RUN: imemREN=1.
//       * ihit & !stall & !redirect: IF/ID <= {imemload, PC+4, valid=1}; PC <= PC+4.
//       * redirect & ihit: PC <= target. IF/ID <= {0, 0, valid=0}. Stays RUN.
//       * redirect & !ihit: target -> redirect buffer. IF/ID flushed. Go to DRAIN.
//       * Redirect beats stall.
//       * stall & !redirect: IF/ID and PC hold. Any ihit that cycle is dropped and refetched.
//       * !ihit & !redirect: IF/ID <= bubble (valid=0) unless stall.
//       * halt (no redirect): go to HALTED.
//     DRAIN: imemREN=1, address held stable until ihit.
//       * On ihit: data discarded; PC <= buffered target; go to RUN.
//       * A new redirect in DRAIN overwrites the buffer (youngest wins).
//       * IF/ID stays bubble.
//     HALTED: imemREN=0; PC frozen; IF/ID <= bubble. Exit only by reset.
//   - Latency: one IF/ID entry per ihit cycle. Redirect costs 1 bubble if ihit same cycle, else 1 + wait cycles.
//   - PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No exception is raised.
// CONFIGURATION
//   FETCH_PERFCNT_EN defined:
//     - Adds out ports fetch_cnt[31:0] (IF/ID valid loads), stall_cnt[31:0] (RUN cycles with stall or !ihit),
//       and flush_cnt[31:0] (redirects accepted).
//     - Counters clear on reset, saturate at 32'hFFFF_FFFF, and freeze in HALTED.
//   Undefined: ports and counters are absent; behaviour otherwise identical.
// STRUCTURE
//   - control_unit_pkg gains fetch_state_t {RUN=2'b00, DRAIN=2'b01, HALTED=2'b10}. pcsrc_t is reused from it.
//   - Sub-module next_pc_sel (combinational): pcsrc, br_taken, three targets -> redirect, target.
//   - Everything else is flat in fetch_stage.
// TESTING
//   1 Reset, then ihit=1 every cycle, 4 cycles -> imemaddr 0,4,8,C; ifid_npc 4,8,C,10; ifid_valid=1 from cycle 2.
//   2 PC=0x10, stall=1 for 3 cycles with ihit=1 -> PC stays 0x10; IF/ID unchanged; after release, PC=0x14 next edge.
//   3 PC=0x20, pcsrc=Bran, br_taken=1, br_addr=0x100, ihit=1 -> next imemaddr=0x100; ifid_valid=0 one cycle.
//     Repeat with br_taken=0 -> PC=0x24.
//   4 PC=0x40, ihit=0, pcsrc=PCJ, j_addr=0x200 -> DRAIN; imemaddr held 0x40 until ihit (3 cycles later).
//     Data dropped; then imemaddr=0x200.
//   5 In DRAIN, pcsrc=PCJr jr_addr=0x300 arrives -> final target 0x300. redirect+stall same cycle -> redirect taken.
//   6 halt=1 -> imemREN=0, PC frozen 20 cycles; nRST=0 mid-DRAIN -> PC=PC_INIT, state RUN, all outputs 0.
//     FETCH_PERFCNT_EN build: fetch_cnt matches valid loads in scenario 1.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared control-path types for the pipeline: PC source select and fetch FSM states.
package control_unit_pkg;

  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned FSTATE_W = 2;

  // PC source chosen by EX for the next fetch
  typedef enum logic [PCSRC_W-1:0] {
    NORM = 2'b00,
    BRAN = 2'b01,
    PCJR = 2'b10,
    PCJ  = 2'b11
  } pcsrc_t;

  // Fetch stage sequencing
  typedef enum logic [FSTATE_W-1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Redirect decode: turns the EX pcsrc selection into a redirect flag and a word-aligned target.
module next_pc_sel
  import control_unit_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  pcsrc_t            pcsrc,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_addr,
  input  logic [WORD_W-1:0] jr_addr,
  input  logic [WORD_W-1:0] j_addr,
  output logic              redirect_c,
  output logic [WORD_W-1:0] target_c
);

  logic [WORD_W-1:0] raw_target;

  // Select target per pcsrc; a branch only redirects when its condition holds
  always_comb begin
    redirect_c = 1'b0;
    raw_target = '0;
    case (pcsrc)
      BRAN: begin
        redirect_c = br_taken;
        raw_target = br_addr;
      end
      PCJR: begin
        redirect_c = 1'b1;
        raw_target = jr_addr;
      end
      PCJ: begin
        redirect_c = 1'b1;
        raw_target = j_addr;
      end
      default: begin
        redirect_c = 1'b0;
        raw_target = '0;
      end
    endcase
    target_c = {raw_target[WORD_W-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives imem reads, holds the IF/ID latch and applies
// redirects from EX. A redirect that misses imem parks its target until the in-flight read lands.
// Optional performance counters are built when FETCH_PERFCNT_EN is defined.
module fetch_stage
  import control_unit_pkg::*;
#(
  parameter int unsigned       WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        pcsrc,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_addr,
  input  logic [WORD_W-1:0] jr_addr,
  input  logic [WORD_W-1:0] j_addr,
  input  logic              stall,
  input  logic              halt,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              ifid_valid
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [WORD_W-1:0] PC_RST = {PC_INIT[WORD_W-1:2], 2'b00};
  localparam logic [WORD_W-1:0] PC_INC = WORD_W'(4);

  fetch_state_t      state;
  fetch_state_t      state_n;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] redir_buf;
  logic              redirect_c;
  logic [WORD_W-1:0] target_c;

  next_pc_sel #(.WORD_W(WORD_W)) u_next_pc_sel (
    .pcsrc      (pcsrc_t'(pcsrc)),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .jr_addr    (jr_addr),
    .j_addr     (j_addr),
    .redirect_c (redirect_c),
    .target_c   (target_c)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!nRST) state <= RUN;
    else       state <= state_n;
  end

  // Next state: a missed redirect drains the pending read; halt (without redirect) is terminal
  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (redirect_c && !ihit)  state_n = DRAIN;
        else if (!redirect_c && halt) state_n = HALTED;
      end
      DRAIN:   if (ihit) state_n = RUN;
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  // FSM outputs: read while running or draining; address is always the PC (held during drain)
  always_comb begin
    imemREN  = 1'b0;
    imemaddr = pc;
    if (nRST && (state == RUN || state == DRAIN)) imemREN = 1'b1;
  end

  // PC, redirect buffer and IF/ID latch; every non-load path inserts an all-zero bubble
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc         <= PC_RST;
      redir_buf  <= '0;
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_c) begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
            if (ihit) pc <= target_c;
            else      redir_buf <= target_c;
          end else if (halt) begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            if (ihit) begin
              ifid_instr <= imemload;
              ifid_npc   <= pc + PC_INC;
              ifid_valid <= 1'b1;
              pc         <= pc + PC_INC;
            end else begin
              ifid_instr <= '0;
              ifid_npc   <= '0;
              ifid_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (redirect_c) redir_buf <= target_c;
          if (ihit)       pc <= redirect_c ? target_c : redir_buf;
          ifid_instr <= '0;
          ifid_npc   <= '0;
          ifid_valid <= 1'b0;
        end
        default: begin
          ifid_instr <= '0;
          ifid_npc   <= '0;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic fetch_inc_c;
  logic stall_inc_c;
  logic flush_inc_c;

  // Counter events; none can fire in HALTED, which freezes the counts
  always_comb begin
    fetch_inc_c = (state == RUN) && !redirect_c && !halt && !stall && ihit;
    stall_inc_c = (state == RUN) && (stall || !ihit);
    flush_inc_c = (state == RUN || state == DRAIN) && redirect_c;
  end

  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fetch_inc_c && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc_c && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc_c && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural fetch model. Counter ports follow FETCH_PERFCNT_EN.
module tb_fetch_stage;
  import control_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  pcsrc;
  logic        br_taken;
  logic [31:0] br_addr, jr_addr, j_addr;
  logic        stall, halt, ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr, ifid_instr, ifid_npc;
  logic        ifid_valid;
`ifdef FETCH_PERFCNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  fetch_stage #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .pcsrc      (pcsrc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .jr_addr    (jr_addr),
    .j_addr     (j_addr),
    .stall      (stall),
    .halt       (halt),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid)
`ifdef FETCH_PERFCNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC, IF/ID contents, pending redirect and halt flag
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_npc, m_buf;
  logic        m_valid, m_drain, m_halted;
  logic [31:0] m_fetch, m_stall, m_flush;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic m_bubble();
    m_instr = 32'h0;
    m_npc   = 32'h0;
    m_valid = 1'b0;
  endtask

  // Compare the DUT against the model, then advance the model using the inputs for the next edge
  initial forever begin
    logic        redir;
    logic [31:0] tgt;
    @(negedge CLK);
    if (m_known) begin
      chk("imemREN",    32'(imemREN),    32'(nRST && !m_halted));
      chk("imemaddr",   imemaddr,        m_pc);
      chk("ifid_instr", ifid_instr,      m_instr);
      chk("ifid_npc",   ifid_npc,        m_npc);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
`ifdef FETCH_PERFCNT_EN
      chk("fetch_cnt",  fetch_cnt,       m_fetch);
      chk("stall_cnt",  stall_cnt,       m_stall);
      chk("flush_cnt",  flush_cnt,       m_flush);
`endif
    end
    redir = (pcsrc == BRAN && br_taken) || pcsrc == PCJR || pcsrc == PCJ;
    tgt   = (pcsrc == BRAN) ? br_addr : (pcsrc == PCJR) ? jr_addr : j_addr;
    tgt   = {tgt[31:2], 2'b00};
    if (!nRST) begin
      m_known  = 1'b1;
      m_pc     = 32'h0;
      m_buf    = 32'h0;
      m_drain  = 1'b0;
      m_halted = 1'b0;
      m_fetch  = 32'h0;
      m_stall  = 32'h0;
      m_flush  = 32'h0;
      m_bubble();
    end else if (m_known) begin
      if (m_halted) begin
        m_bubble();
      end else if (m_drain) begin
        if (redir) begin
          m_buf   = tgt;
          m_flush = sat_inc(m_flush);
        end
        if (ihit) begin
          m_pc    = m_buf;
          m_drain = 1'b0;
        end
        m_bubble();
      end else begin
        if (stall || !ihit) m_stall = sat_inc(m_stall);
        if (redir) begin
          m_flush = sat_inc(m_flush);
          m_bubble();
          if (ihit) m_pc = tgt;
          else begin
            m_buf   = tgt;
            m_drain = 1'b1;
          end
        end else if (halt) begin
          m_halted = 1'b1;
          m_bubble();
        end else if (!stall) begin
          if (ihit) begin
            m_instr = imemload;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetch = sat_inc(m_fetch);
          end else begin
            m_bubble();
          end
        end
      end
    end
  end

  // Advance one edge; imem returns a word tagged with the address now being fetched
  task automatic tick();
    @(posedge CLK);
    #1;
    imemload = 32'hC0DE_0000 | {16'h0, m_pc[15:0]};
  endtask

  task automatic set_ctl(input logic [1:0] src, input logic tk, input logic [31:0] a);
    pcsrc    = src;
    br_taken = tk;
    br_addr  = a;
    jr_addr  = a;
    j_addr   = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; stall = 1'b0; halt = 1'b0; ihit = 1'b0;
    imemload = 32'hC0DE_0000;
    set_ctl(NORM, 1'b0, 32'h0);
    tick(); tick();
    chk("rst imemREN", 32'(imemREN), 32'h0);
    chk("rst imemaddr", imemaddr, 32'h0);
    chk("rst valid", 32'(ifid_valid), 32'h0);
    chk("rst instr", ifid_instr, 32'h0);
    chk("rst npc", ifid_npc, 32'h0);

    // Straight-line fetch
    nRST = 1'b1; ihit = 1'b1;
    #1;
    chk("s1 imemREN", 32'(imemREN), 32'h1);
    chk("s1 addr0", imemaddr, 32'h0);
    tick();
    chk("s1 addr1", imemaddr, 32'h4);
    chk("s1 npc1", ifid_npc, 32'h4);
    chk("s1 valid1", 32'(ifid_valid), 32'h1);
    chk("s1 instr1", ifid_instr, 32'hC0DE_0000);
    tick();
    chk("s1 addr2", imemaddr, 32'h8);
    chk("s1 npc2", ifid_npc, 32'h8);
    tick();
    chk("s1 addr3", imemaddr, 32'hC);
    chk("s1 npc3", ifid_npc, 32'hC);
    tick();
    chk("s1 addr4", imemaddr, 32'h10);
    chk("s1 npc4", ifid_npc, 32'h10);
    chk("s1 instr4", ifid_instr, 32'hC0DE_000C);
`ifdef FETCH_PERFCNT_EN
    chk("s1 fetch_cnt", fetch_cnt, 32'd4);
    chk("s1 stall_cnt", stall_cnt, 32'd0);
`endif

    // Stall holds PC and IF/ID even though imem hits
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2 hold addr", imemaddr, 32'h10);
      chk("s2 hold npc", ifid_npc, 32'h10);
      chk("s2 hold instr", ifid_instr, 32'hC0DE_000C);
    end
    stall = 1'b0;
    tick();
    chk("s2 release addr", imemaddr, 32'h14);
    chk("s2 release instr", ifid_instr, 32'hC0DE_0010);
    tick(); tick(); tick();
    chk("s3 start addr", imemaddr, 32'h20);

    // Taken branch with hit, jump back, then untaken branch
    set_ctl(BRAN, 1'b1, 32'h100);
    tick();
    chk("s3 taken addr", imemaddr, 32'h100);
    chk("s3 taken valid", 32'(ifid_valid), 32'h0);
    set_ctl(PCJ, 1'b0, 32'h20);
    tick();
    chk("s3 back addr", imemaddr, 32'h20);
    set_ctl(BRAN, 1'b0, 32'h100);
    tick();
    chk("s3 untaken addr", imemaddr, 32'h24);
    chk("s3 untaken npc", ifid_npc, 32'h24);
    chk("s3 untaken valid", 32'(ifid_valid), 32'h1);
    set_ctl(PCJR, 1'b0, 32'h43);
    tick();
    chk("jr align addr", imemaddr, 32'h40);

    // Redirect on a miss drains the outstanding read
    set_ctl(PCJ, 1'b0, 32'h200); ihit = 1'b0;
    tick();
    chk("s4 drain addr", imemaddr, 32'h40);
    chk("s4 drain ren", 32'(imemREN), 32'h1);
    set_ctl(NORM, 1'b0, 32'h0);
    tick(); tick();
    chk("s4 held addr", imemaddr, 32'h40);
    ihit = 1'b1;
    tick();
    chk("s4 target addr", imemaddr, 32'h200);
    chk("s4 dropped valid", 32'(ifid_valid), 32'h0);
    tick();
    chk("s4 fetch npc", ifid_npc, 32'h204);
    chk("s4 fetch instr", ifid_instr, 32'hC0DE_0200);
    ihit = 1'b0;
    tick();
    chk("miss bubble", 32'(ifid_valid), 32'h0);
    chk("miss addr", imemaddr, 32'h204);

    // Youngest redirect wins during drain; redirect beats stall
    set_ctl(BRAN, 1'b1, 32'h280);
    tick();
    set_ctl(PCJR, 1'b0, 32'h300);
    tick();
    chk("s5 drain addr", imemaddr, 32'h204);
    set_ctl(NORM, 1'b0, 32'h0); ihit = 1'b1;
    tick();
    chk("s5 youngest addr", imemaddr, 32'h300);
    stall = 1'b1; set_ctl(PCJ, 1'b0, 32'h3F0);
    tick();
    chk("s5 redir over stall", imemaddr, 32'h3F0);
    stall = 1'b0;

    // PC+4 wraps at the top of the address space
    set_ctl(PCJ, 1'b0, 32'hFFFF_FFFC);
    tick();
    chk("wrap top", imemaddr, 32'hFFFF_FFFC);
    set_ctl(NORM, 1'b0, 32'h0);
    tick();
    chk("wrap addr", imemaddr, 32'h0);
    chk("wrap npc", ifid_npc, 32'h0);
    chk("wrap valid", 32'(ifid_valid), 32'h1);
    tick();

    // Halt is permanent: redirects and hits are ignored
    halt = 1'b1;
    tick();
    chk("halt ren", 32'(imemREN), 32'h0);
    chk("halt addr", imemaddr, 32'h4);
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) set_ctl(PCJ, 1'b0, 32'h500);
      else            set_ctl(NORM, 1'b0, 32'h0);
      tick();
      chk("halted addr", imemaddr, 32'h4);
      chk("halted ren", 32'(imemREN), 32'h0);
    end

    // Reset out of HALTED, then reset again in the middle of a drain
    set_ctl(NORM, 1'b0, 32'h0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    chk("rerun addr", imemaddr, 32'h4);
    ihit = 1'b0; set_ctl(PCJ, 1'b0, 32'h600);
    tick();
    set_ctl(NORM, 1'b0, 32'h0);
    nRST = 1'b0;
    tick();
    chk("mid-drain rst addr", imemaddr, 32'h0);
    chk("mid-drain rst ren", 32'(imemREN), 32'h0);
    chk("mid-drain rst valid", 32'(ifid_valid), 32'h0);
    chk("mid-drain rst npc", ifid_npc, 32'h0);
    nRST = 1'b1; ihit = 1'b1;
    tick();
    chk("post rst addr", imemaddr, 32'h4);
    chk("post rst npc", ifid_npc, 32'h4);
    tick(); tick();
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
